// File: rtl/and_result_skid.sv
// Registered 2-entry skid buffer downstream of the AND stage, with
// saturating accept/zero-beat counters for observability.
module and_result_skid #(
    parameter int G_WIDTH     = 8,
    parameter int G_CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [G_WIDTH-1:0]     in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [G_WIDTH-1:0]     out_data,
    output logic                   out_zero,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clr_cnt,
    output logic [G_CNT_WIDTH-1:0] cnt_total,
    output logic [G_CNT_WIDTH-1:0] cnt_zero
);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [G_WIDTH-1:0]     main_data;
    logic [G_WIDTH-1:0]     skid_data;
    logic                   main_zero;
    logic                   skid_zero;
    logic                   accept;
    logic                   pop;
    logic                   in_zero;
    logic                   load_main;
    logic                   load_skid;
    logic                   main_from_skid;
    logic [G_CNT_WIDTH-1:0] total_base;
    logic [G_CNT_WIDTH-1:0] zero_base;
    logic [G_CNT_WIDTH-1:0] total_nxt;
    logic [G_CNT_WIDTH-1:0] zero_nxt;

    // Ready depends only on state and reset, so no path back from out_ready.
    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign in_zero   = (in_data == '0);
    assign out_data  = main_data;
    assign out_zero  = main_zero;

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_nxt = FULL;
                    load_skid = 1'b1;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_nxt      = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Zero flag travels with its beat rather than being decoded at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_data <= '0;
            main_zero <= 1'b0;
            skid_data <= '0;
            skid_zero <= 1'b0;
        end else begin
            if (load_main) begin
                main_data <= in_data;
                main_zero <= in_zero;
            end else if (main_from_skid) begin
                main_data <= skid_data;
                main_zero <= skid_zero;
            end
            if (load_skid) begin
                skid_data <= in_data;
                skid_zero <= in_zero;
            end
        end
    end

    // Clear takes effect first, then the same-cycle beat is counted.
    always_comb begin
        total_base = clr_cnt ? '0 : cnt_total;
        zero_base  = clr_cnt ? '0 : cnt_zero;
        total_nxt  = total_base;
        zero_nxt   = zero_base;
        if (accept && (total_base != '1)) begin
            total_nxt = total_base + 1'b1;
        end
        if (accept && in_zero && (zero_base != '1)) begin
            zero_nxt = zero_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_total <= '0;
            cnt_zero  <= '0;
        end else begin
            cnt_total <= total_nxt;
            cnt_zero  <= zero_nxt;
        end
    end

endmodule

// File: doc/and_result_skid.md
# and_result_skid

Registered output stage that sits directly downstream of `and1`. It captures the `G_WIDTH`-bit AND result `c` under a valid/ready handshake and presents it through a 2-entry skid buffer, so backpressure never forms a combinational path back into the AND stage. It also keeps saturating statistics counters: total results accepted and all-zero results accepted. These give the lib_tb_a bench and later integration a cheap observability point.

## Interface
Parameters:
- `G_WIDTH`, 8, data width; must match the `G_WIDTH` of the upstream `and1`.
- `G_CNT_WIDTH`, 16, width of each statistics counter.

Ports:
- `clk`  in  1  single clock; every register is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  `G_WIDTH`  AND result, driven from `and1.c`.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `out_data`  out  `G_WIDTH`  head-of-buffer result.
- `out_zero`  out  1  `out_data` equals all zeros; qualified by `out_valid`.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  the consumer takes `out_data` this cycle.
- `clr_cnt`  in  1  synchronous clear of both counters.
- `cnt_total`  out  `G_CNT_WIDTH`  number of accepted input beats, saturating.
- `cnt_zero`  out  `G_CNT_WIDTH`  number of accepted all-zero beats, saturating.

## Operation
- Definitions: accept = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- Storage is two registers. `main` drives `out_data`/`out_zero`; `skid` holds an overflow beat.
- The state machine has three states: EMPTY, ONE (`main` valid), FULL (`main` and `skid` valid).
- `in_ready` = (state != FULL) and not `rst`. It is a function of registers and `rst` only, never of `out_ready`.
- `out_valid` = (state != EMPTY).
- Transitions in EMPTY:
  - accept -> ONE, `main` <= `in_data`.
  - otherwise stay in EMPTY.
- Transitions in ONE:
  - accept & pop -> ONE, `main` <= `in_data`.
  - accept & !pop -> FULL, `skid` <= `in_data`.
  - pop & !accept -> EMPTY.
  - neither -> stay in ONE.
- Transitions in FULL (no accept is possible):
  - pop -> ONE, `main` <= `skid`.
  - otherwise stay in FULL.
- Ordering is strict FIFO. No beat is dropped or duplicated.
- `out_zero` is computed from the input when the beat is written and stored alongside it, in `main` or `skid`. It is never decoded from `out_data` at the output.
- `out_data` and `out_zero` keep their last value when the state returns to EMPTY.
- Counter rules:
  - `cnt_total` increments on each accept.
  - `cnt_zero` increments on each accept where `in_data` == 0.
  - Both counters saturate at all-ones and never wrap.
- `clr_cnt` with an accept in the same cycle: the clear wins, then that beat is counted. The result is 1, or 0 for `cnt_zero` when the beat is nonzero.
- `clr_cnt` has no effect on the buffer or the handshake.

## Timing
- Reset values, applied at the first `clk` edge with `rst` high:
  - state = EMPTY; `out_valid` = 0.
  - `out_data`, `skid` = 0; `out_zero` = 0.
  - `cnt_total`, `cnt_zero` = 0.
- `in_ready` is 0 while `rst` is high and 1 on the first cycle after `rst` falls.
- `rst` asserted mid-operation: buffered beats are discarded and everything returns to reset values at the next edge. Input present in the same cycle is not accepted.
- Latency: a beat accepted in cycle N while EMPTY gives `out_valid` = 1 with that data in cycle N+1.
- Throughput: 1 beat per cycle in steady state with `out_ready` held high; the state stays ONE.
- After one cycle with `out_ready` low, the buffer absorbs exactly one extra beat. `in_ready` drops in the following cycle.
- After `out_ready` rises in FULL, `in_ready` returns 1 in the next cycle.
- Counter outputs update one cycle after the accept.

## Test plan
- Reset then stream: `in_data` 0xFF, 0x0F, 0x00 back-to-back with `out_ready` = 1 -> out sequence 0xFF, 0x0F, 0x00 on cycles 1-3. `out_zero` is high only on the third beat. `cnt_total` = 3, `cnt_zero` = 1.
- Backpressure: `out_ready` = 0 while 0xA5 then 0x5A are offered -> state FULL and `in_ready` = 0 with 0xA5 held at the output. Raising `out_ready` drains 0xA5 then 0x5A, and `in_ready` returns to 1.
- Random stimulus: random `in_valid`/`out_ready` over 1000 cycles, with data from `and1` on random a/b -> output order equals accepted order (scoreboard). No handshake violation; counters match the model.
- Saturation: `G_CNT_WIDTH` = 4 with 20 beats of 0x00 -> `cnt_total` = `cnt_zero` = 15.
- Clear collision: `clr_cnt` asserted on the same cycle as accepting 0x00 with counts at 7 -> next cycle both counters = 1.
- Reset mid-flight: `rst` pulsed for 1 cycle while FULL -> `out_valid` = 0 and counters = 0 next cycle. `in_ready` = 1 the cycle after `rst` falls.
